button_conditioner: RTL and testbench

Upstream front-end for the up/down duty-level counter. It takes the two raw, asynchronous push-button inputs (increase, decrease), synchronises and debounces each one, and emits single-cycle increment/decrement pulses. Pulses are generated on a press and optionally auto-repeat while the button is held. Its pulse outputs drive the counter's incr/decr inputs directly in place of the raw button pins.

---
 rtl/button_conditioner.sv | 127 ++++++++++++
 tb/tb_button_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-channel push-button front end: synchronise, debounce, and turn presses into
// single-cycle incr/decr pulses with optional auto-repeat while held.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic incr_btn_i,
    input  logic decr_btn_i,
    output logic incr_o,
    output logic decr_o,
    output logic incr_lvl_o,
    output logic decr_lvl_o
);

    localparam int unsigned DcW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RcMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RcW   = $clog2(RcMax);

    localparam logic [DcW-1:0] DcLast     = DcW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RcW-1:0] DelayLast  = RcW'(REPEAT_DELAY - 1);
    localparam logic [RcW-1:0] PeriodLast = RcW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] raise;
    logic [1:0] pulse_q;

    // Bit 0 is the increase channel, bit 1 the decrease channel.
    assign btn = {decr_btn_i, incr_btn_i};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic           s1_q;
        logic           s2_q;
        logic           d_q;
        logic [DcW-1:0] dc_q;
        logic [RcW-1:0] rc_q;
        logic [RcW-1:0] rc_d;
        state_e         state_q;
        state_e         state_d;
        logic           raise_c;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                d_q     <= 1'b0;
                dc_q    <= '0;
                rc_q    <= '0;
                state_q <= StIdle;
            end else begin
                s1_q    <= btn[ch];
                s2_q    <= s1_q;
                rc_q    <= rc_d;
                state_q <= state_d;
                if (s2_q == d_q) begin
                    dc_q <= '0;
                end else if (dc_q == DcLast) begin
                    d_q  <= s2_q;
                    dc_q <= '0;
                end else begin
                    dc_q <= dc_q + 1'b1;
                end
            end
        end

        always_comb begin
            state_d = state_q;
            rc_d    = rc_q;
            raise_c = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (d_q) begin
                        state_d = StHold;
                        rc_d    = '0;
                        raise_c = 1'b1;
                    end
                end
                StHold: begin
                    if (!d_q) begin
                        state_d = StIdle;
                    end else if ((REPEAT_EN != 0) && (rc_q == DelayLast)) begin
                        state_d = StRepeat;
                        rc_d    = '0;
                        raise_c = 1'b1;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (!d_q) begin
                        state_d = StIdle;
                    end else if (rc_q == PeriodLast) begin
                        rc_d    = '0;
                        raise_c = 1'b1;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        assign lvl[ch]   = d_q;
        assign raise[ch] = raise_c;
    end

    // Pulses raised while both buttons are accepted as held are dropped, not deferred.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= raise & {2{~(lvl[0] & lvl[1])}};
        end
    end

    assign incr_o     = pulse_q[0];
    assign decr_o     = pulse_q[1];
    assign incr_lvl_o = lvl[0];
    assign decr_lvl_o = lvl[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulse edges are queued per test and
// compared against the pulse edges recorded by a monitor.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic incr_btn = 1'b0;
    logic decr_btn = 1'b0;
    logic incr, decr, incr_lvl, decr_lvl;
    logic nr_incr, nr_decr, nr_incr_lvl, nr_decr_lvl;

    int checks = 0;
    int errors = 0;
    int edge_n = -1;
    int t0 = 0;
    int exp_q[$];
    int incr_seen[$];
    int decr_seen[$];
    int nr_incr_seen[$];

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .incr_btn_i(incr_btn), .decr_btn_i(decr_btn),
        .incr_o(incr), .decr_o(decr), .incr_lvl_o(incr_lvl), .decr_lvl_o(decr_lvl)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_nr (
        .clk_i(clk), .rst_ni(rst_n), .incr_btn_i(incr_btn), .decr_btn_i(decr_btn),
        .incr_o(nr_incr), .decr_o(nr_decr), .incr_lvl_o(nr_incr_lvl), .decr_lvl_o(nr_decr_lvl)
    );

    // Record the edge (relative to t0) after which each pulse output is seen high.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        #1;
        if (incr) incr_seen.push_back(edge_n - t0);
        if (decr) decr_seen.push_back(edge_n - t0);
        if (nr_incr) nr_incr_seen.push_back(edge_n - t0);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns 2 ns after the posedge numbered rel (relative to t0).
    task automatic at_edge(input int rel);
        int guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while ((edge_n - t0 < rel) && (guard < 1000));
        if (guard >= 1000) check("at_edge timeout", edge_n - t0, rel);
    endtask

    task automatic start_test();
        t0 = edge_n + 1;
        incr_seen.delete();
        decr_seen.delete();
        nr_incr_seen.delete();
        exp_q.delete();
    endtask

    task automatic check_pulses(input string tag, input int sel);
        int got[$];
        int n;
        if (sel == 0) got = incr_seen;
        else if (sel == 1) got = decr_seen;
        else got = nr_incr_seen;
        check({tag, " count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " edge"}, got[i], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        logic [6:0] bounce;

        // Test 1: asynchronous reset mid-operation.
        #12;
        rst_n = 1'b1;
        start_test();
        incr_btn = 1'b1;
        at_edge(7);
        check("t1 lvl before reset", int'(incr_lvl), 1);
        #1;
        rst_n = 1'b0;
        decr_btn = 1'b1;
        #1;
        check("t1 outputs in reset", int'({incr, decr, incr_lvl, decr_lvl}), 0);
        for (int i = 0; i < 3; i++) begin
            at_edge(8 + i);
            incr_btn = ~incr_btn;
            decr_btn = ~decr_btn;
        end
        incr_btn = 1'b0;
        decr_btn = 1'b0;
        at_edge(12);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            at_edge(13 + i);
            check("t1 outputs after release", int'({incr, decr, incr_lvl, decr_lvl}), 0);
        end

        // Test 2: single press without repeat.
        at_edge(25);
        start_test();
        incr_btn = 1'b1;
        at_edge(4);
        check("t2 lvl at edge 4", int'(nr_incr_lvl), 0);
        at_edge(5);
        check("t2 lvl at edge 5", int'(nr_incr_lvl), 1);
        at_edge(9);
        incr_btn = 1'b0;
        at_edge(25);
        exp_q.push_back(6);
        check_pulses("t2 nr incr", 2);
        check_pulses("t2 decr", 1);

        // Test 3: bounce shorter than the debounce window.
        start_test();
        bounce = 7'b0110111;
        for (int i = 0; i < 7; i++) begin
            incr_btn = bounce[i];
            at_edge(i);
        end
        incr_btn = 1'b0;
        for (int i = 7; i < 16; i++) begin
            at_edge(i);
            check("t3 lvl stays low", int'(incr_lvl), 0);
        end
        check_pulses("t3 incr", 0);

        // Test 4: long hold with auto-repeat, then release.
        at_edge(20);
        start_test();
        incr_btn = 1'b1;
        at_edge(59);
        incr_btn = 1'b0;
        at_edge(64);
        check("t4 lvl at edge 64", int'(incr_lvl), 1);
        at_edge(65);
        check("t4 lvl at edge 65", int'(incr_lvl), 0);
        at_edge(80);
        exp_q.push_back(6);
        exp_q.push_back(26);
        exp_q.push_back(34);
        exp_q.push_back(42);
        exp_q.push_back(50);
        exp_q.push_back(58);
        check_pulses("t4 incr", 0);

        // Test 5: both held masks pulses; incr resumes after decr release.
        start_test();
        incr_btn = 1'b1;
        decr_btn = 1'b1;
        at_edge(39);
        decr_btn = 1'b0;
        at_edge(44);
        check("t5 decr lvl at edge 44", int'(decr_lvl), 1);
        at_edge(45);
        check("t5 decr lvl at edge 45", int'(decr_lvl), 0);
        at_edge(59);
        incr_btn = 1'b0;
        at_edge(80);
        exp_q.push_back(50);
        exp_q.push_back(58);
        check_pulses("t5 incr", 0);
        check_pulses("t5 decr", 1);

        // Test 6: reset while decr held restarts it as a fresh press.
        start_test();
        decr_btn = 1'b1;
        at_edge(30);
        check("t6 lvl before reset", int'(decr_lvl), 1);
        rst_n = 1'b0;
        #1;
        check("t6 outputs in reset", int'({decr, decr_lvl}), 0);
        at_edge(31);
        check("t6 decr during reset", int'(decr), 0);
        at_edge(32);
        rst_n = 1'b1;
        at_edge(68);
        decr_btn = 1'b0;
        at_edge(90);
        exp_q.push_back(6);
        exp_q.push_back(26);
        exp_q.push_back(33 + 6);
        exp_q.push_back(33 + 26);
        exp_q.push_back(33 + 34);
        check_pulses("t6 decr", 1);
        check_pulses("t6 incr", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
